// File: rtl/e203_ifu_ift2mem.sv
// Instruction fetch bridge: turns ifetch REQ/RSP handshakes into word reads on a
// read-only ICB port, stitching halfword-aligned fetches and reusing a leftover halfword.
module e203_ifu_ift2mem #(
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_req_seq,
  output logic               ifu_rsp_valid,
  input  logic               ifu_rsp_ready,
  output logic               ifu_rsp_err,
  output logic [31:0]        ifu_rsp_instr,
  output logic               icb_cmd_valid,
  input  logic               icb_cmd_ready,
  output logic [PC_SIZE-1:0] icb_cmd_addr,
  input  logic               icb_rsp_valid,
  output logic               icb_rsp_ready,
  input  logic               icb_rsp_err,
  input  logic [31:0]        icb_rsp_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD1 = 3'd1,
    RSP1 = 3'd2,
    CMD2 = 3'd3,
    RSP2 = 3'd4,
    OUT  = 3'd5
  } state_t;

  localparam logic [PC_SIZE-1:0] HALF_STEP = PC_SIZE'(32'd2);
  localparam logic [PC_SIZE-1:0] WORD_STEP = PC_SIZE'(32'd4);

  state_t             state_r, state_nxt_s;
  logic [PC_SIZE-1:0] addr_r;
  logic [PC_SIZE-1:0] lo_tag_r;
  logic [15:0]        lo_half_r;
  logic               lo_vld_r;
  logic               miss_r;
  logic               cmd_valid_r;
  logic               rsp_valid_r;
  logic               err_r;
  logic [31:0]        instr_r;
  logic               req_hsk_s, cmd_hsk_s, rsp_hsk_s, out_hsk_s, hit_s;

  assign ifu_req_ready = (state_r == IDLE);
  assign icb_rsp_ready = (state_r == RSP1) || (state_r == RSP2);
  assign req_hsk_s     = ifu_req_valid & ifu_req_ready;
  assign cmd_hsk_s     = cmd_valid_r & icb_cmd_ready;
  assign rsp_hsk_s     = icb_rsp_valid & icb_rsp_ready;
  assign out_hsk_s     = rsp_valid_r & ifu_rsp_ready;
  // A non-sequential request never hits, whatever the buffer holds.
  assign hit_s = ifu_req_pc[1] & ifu_req_seq & lo_vld_r & (ifu_req_pc == lo_tag_r);

  assign icb_cmd_valid = cmd_valid_r;
  assign icb_cmd_addr  = addr_r;
  assign ifu_rsp_valid = rsp_valid_r;
  assign ifu_rsp_err   = err_r;
  assign ifu_rsp_instr = instr_r;

  // Next-state logic for the fetch sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_hsk_s) state_nxt_s = hit_s ? CMD2 : CMD1;
        else           state_nxt_s = IDLE;
      end
      CMD1: begin
        if (cmd_hsk_s) state_nxt_s = RSP1;
        else           state_nxt_s = CMD1;
      end
      RSP1: begin
        if (rsp_hsk_s) state_nxt_s = (icb_rsp_err || !miss_r) ? OUT : CMD2;
        else           state_nxt_s = RSP1;
      end
      CMD2: begin
        if (cmd_hsk_s) state_nxt_s = RSP2;
        else           state_nxt_s = CMD2;
      end
      RSP2: begin
        if (rsp_hsk_s) state_nxt_s = OUT;
        else           state_nxt_s = RSP2;
      end
      OUT: begin
        if (out_hsk_s) state_nxt_s = IDLE;
        else           state_nxt_s = OUT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered handshake valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cmd_valid_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_valid_r <= (state_nxt_s == CMD1) || (state_nxt_s == CMD2);
      rsp_valid_r <= (state_nxt_s == OUT);
    end
  end

  // Fetch address, instruction assembly, error flag and leftover-halfword buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r    <= {PC_SIZE{1'b0}};
      lo_tag_r  <= {PC_SIZE{1'b0}};
      lo_half_r <= 16'h0000;
      lo_vld_r  <= 1'b0;
      miss_r    <= 1'b0;
      err_r     <= 1'b0;
      instr_r   <= 32'h0000_0000;
    end else if (req_hsk_s) begin
      err_r  <= 1'b0;
      miss_r <= ifu_req_pc[1] & ~hit_s;
      if (hit_s) begin
        addr_r  <= ifu_req_pc + HALF_STEP;
        instr_r <= {16'h0000, lo_half_r};
      end else begin
        addr_r  <= {ifu_req_pc[PC_SIZE-1:2], 2'b00};
      end
      if (!ifu_req_seq) lo_vld_r <= 1'b0;
    end else if (rsp_hsk_s) begin
      if (icb_rsp_err) begin
        err_r    <= 1'b1;
        instr_r  <= 32'h0000_0000;
        lo_vld_r <= 1'b0;
      end else begin
        lo_half_r <= icb_rsp_rdata[31:16];
        lo_tag_r  <= addr_r + HALF_STEP;
        lo_vld_r  <= 1'b1;
        // The second beat always supplies the upper halfword.
        if (state_r == RSP2) begin
          instr_r[31:16] <= icb_rsp_rdata[15:0];
        end else if (miss_r) begin
          instr_r[15:0] <= icb_rsp_rdata[31:16];
          addr_r        <= addr_r + WORD_STEP;
        end else begin
          instr_r <= icb_rsp_rdata;
        end
      end
    end
  end

endmodule
